// File: rtl/add32_seq_pkg.sv
// Shared constants, operation codes and FSM encoding for the nibble-serial adder.
package add32_seq_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int NSTEP_DEFAULT = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add32_seq_cla4_slice.sv
// 4-bit carry-lookahead adder slice; every carry is expanded from p/g terms.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:1] c;

    // Propagate/generate terms and fully flattened lookahead carries.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ {c[3], c[2], c[1], cin};
        cout = c[4];
    end

endmodule

// File: rtl/add32_seq.sv
// Nibble-serial add/subtract unit: one 4-bit lookahead slice reused over NSTEP
// clock edges, with a valid/ready request side and a valid/ready result side.
module add32_seq
    import add32_seq_pkg::*;
#(
    parameter int NSTEP = NSTEP_DEFAULT,
    localparam int W    = NIBBLE_W * NSTEP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         busy
);

    localparam int SW                 = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

    state_t        state;
    logic [SW-1:0] step;
    logic          c;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  sum_next;
    logic          out_valid_reg;
    logic          cout_reg;
    logic          ovf_reg;
    logic          zero_reg;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign slice_a = a_reg[NIBBLE_W*step +: NIBBLE_W];
    assign slice_b = b_reg[NIBBLE_W*step +: NIBBLE_W];

    cla4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (c),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Result word as it will look after the current nibble is written; the
    // final-step flags are computed from this so they match the stored sum.
    always_comb begin
        sum_next = sum_reg;
        sum_next[NIBBLE_W*step +: NIBBLE_W] = slice_sum;
    end

    // Control FSM with operand, result and flag registers. The operation code
    // is folded into the stored b operand and carry at accept time, so it is
    // not kept separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            step          <= '0;
            c             <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= (op == OP_ADD) ? b : ~b;
                        c       <= (op == OP_ADD) ? cin : 1'b1;
                        sum_reg <= '0;
                        step    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_reg <= sum_next;
                    c       <= slice_cout;
                    if (step == LAST_STEP) begin
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                        cout_reg      <= slice_cout;
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &&
                                         (sum_next[W-1] != a_reg[W-1]);
                        zero_reg      <= (sum_next == '0);
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                        cout_reg      <= 1'b0;
                        ovf_reg       <= 1'b0;
                        zero_reg      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_add32_seq.sv
// Scoreboard bench for add32_seq: expected results are queued at request time
// and compared when the result handshake appears.
module tb_add32_seq;

    localparam int NSTEP = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        busy;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } req_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    add32_seq #(.NSTEP(NSTEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, need completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic: 33-bit add of a, effective b and effective carry.
    function automatic exp_t model(input logic mop, input logic [31:0] ma,
                                   input logic [31:0] mb, input logic mcin);
        exp_t        m;
        logic [31:0] bb;
        logic        cc;
        logic [32:0] r;
        bb     = mop ? ~mb : mb;
        cc     = mop ? 1'b1 : mcin;
        r      = {1'b0, ma} + {1'b0, bb} + {32'd0, cc};
        m.sum  = r[31:0];
        m.cout = r[32];
        m.ovf  = (ma[31] == bb[31]) && (r[31] != ma[31]);
        m.zero = (r[31:0] == 32'd0);
        return m;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, need 0x%08h", tag, got, expv);
        end
    endtask

    // Present one request, queue its expected result and wait for acceptance.
    task automatic applyStimulus(input req_t r);
        logic accepted;
        accepted = 1'b0;
        @(negedge clk);
        op       = r.op;
        a        = r.a;
        b        = r.b;
        cin      = r.cin;
        in_valid = 1'b1;
        exp_q.push_back(model(r.op, r.a, r.b, r.cin));
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept to out_valid, then compare against the scoreboard.
    task automatic collectResult(input logic do_release);
        int   lat;
        exp_t e;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            checkOutput("run_flags", 32'({cout, ovf, zero}), 32'd0);
            checkOutput("run_in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("latency", 32'(lat), 32'(NSTEP));
        checkOutput("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_exp = e;
            checkOutput("sum", sum, e.sum);
            checkOutput("cout", 32'(cout), 32'(e.cout));
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
            checkOutput("zero", 32'(zero), 32'(e.zero));
        end
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput("rel_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
            checkOutput("rel_flags", 32'({cout, ovf, zero}), 32'd0);
        end
    endtask

    req_t vec [0:5] = '{
        '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0},
        '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0},
        '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1},
        '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0},
        '{1'b0, 32'h1234_5678, 32'h0FED_CBA8, 1'b1},
        '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0}
    };

    initial begin
        req_t r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        cin       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum", sum, 32'd0);
        checkOutput("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic vectors.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec[i]);
            checkOutput("busy_run", 32'(busy), 32'd1);
            collectResult(1'b1);
        end

        // A few random operations.
        for (int i = 0; i < 4; i++) begin
            r.op  = 1'($urandom_range(0, 1));
            r.a   = $urandom;
            r.b   = $urandom;
            r.cin = 1'($urandom_range(0, 1));
            applyStimulus(r);
            collectResult(1'b1);
        end

        // Backpressure in DONE while a second request is already waiting.
        applyStimulus('{1'b0, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0});
        collectResult(1'b0);
        op       = 1'b1;
        a        = 32'h0000_0100;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_sum", sum, last_exp.sum);
            checkOutput("bp_flags", 32'({cout, ovf, zero}),
                        32'({last_exp.cout, last_exp.ovf, last_exp.zero}));
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_rel_out_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(model(op, a, b, cin));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_accept_busy", 32'(busy), 32'd1);
        collectResult(1'b1);

        // Asynchronous reset in the middle of RUN.
        applyStimulus('{1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0});
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_sum", sum, 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_flags", 32'({cout, ovf, zero}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('{1'b0, 32'd3, 32'd4, 1'b0});
        collectResult(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
